uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
UART receive front-end that sits directly upstream of the deserializer. It synchronises the asynchronous serial line and detects and validates the start bit. Each data bit is majority-sampled at mid-bit using an oversampling baud tick. Each recovered data bit is presented with a one-cycle strobe, in line order (first received bit first). Frame completion and framing errors are also flagged.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period; even, minimum 8
DATA_BITS, 8, data bits per frame (5..9)
SYNC_STAGES, 2, flops in the rx_in synchroniser (minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
rx_in  input  1  asynchronous serial line, idle high
baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rcv_bit  output  1  last recovered data bit; holds between strobes
rcv_bit_valid  output  1  one-clk strobe: rcv_bit is a new data bit
frame_done  output  1  one-clk strobe: valid stop bit received
framing_error  output  1  one-clk strobe: stop bit sampled low
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All flops update on posedge clk only.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; tick_cnt and bit_cnt go to 0.
  - Synchroniser stages load 1.
  - All outputs go to 0.
  - Reset mid-frame abandons the frame silently; no strobes are emitted.
- Synchroniser: rx_in passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Counter advance: tick_cnt ($clog2(OVERSAMPLE) bits) and all state changes advance only on clk edges where baud_tick=1. Cycles without baud_tick change nothing except that strobes clear.
- Sampling window: samples are taken when tick_cnt = M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the 3 samples, decided on the tick where tick_cnt = M+1.
- States:
  - IDLE: on a tick with rx_s=0, go to START with tick_cnt=0.
  - START: at the decision tick, a majority of 1 is a false start; return to IDLE with no strobe. Otherwise, on the tick where tick_cnt = OVERSAMPLE-1, wrap tick_cnt to 0, set bit_cnt=0 and go to DATA.
  - DATA: at the decision tick, register rcv_bit <= majority and pulse rcv_bit_valid for exactly one clk, on the edge following the decision tick. On the tick where tick_cnt = OVERSAMPLE-1, wrap tick_cnt and increment bit_cnt. When bit_cnt = DATA_BITS-1 wraps, go to STOP.
  - STOP: at the decision tick, a majority of 1 pulses frame_done and goes to IDLE immediately. This gives half a bit of slack so back-to-back frames work. A majority of 0 pulses framing_error and goes to WAIT_IDLE.
  - WAIT_IDLE: on a tick with rx_s=1, go to IDLE. A held break therefore produces exactly one framing_error and no further frames.
- Strobe timing: frame_done and framing_error use the same timing as rcv_bit_valid. The three strobes are mutually exclusive and never last longer than one clk.
- rx_busy is combinational from state: high when state is not IDLE.
- Cadence: baud_tick may be continuous (every clk). Behaviour is identical apart from timing.
- Exactly DATA_BITS rcv_bit_valid strobes occur per accepted start bit, unless reset intervenes.

Decomposition:
- Shared package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}
  - constant UART_OVERSAMPLE_DEFAULT = 16
  - constant UART_DATA_BITS_DEFAULT = 8
- Sub-module uart_rx_sync holds the parameterised SYNC_STAGES synchroniser with reset value 1. It is reused by other UART line inputs.
- Majority vote and counters stay inline.

Test Plan:
- Nominal frame: baud_tick every 4 clk; send 0xA5 LSB-first (bits 1,0,1,0,0,1,0,1) plus stop=1 -> 8 rcv_bit_valid strobes carrying 1,0,1,0,0,1,0,1, then frame_done once; framing_error never asserts; rx_busy falls with frame_done.
- False start: rx_in low for 3 baud_ticks, then high -> no rcv_bit_valid strobe; rx_busy high for at most M+2 ticks, then back to IDLE.
- Noise rejection: send 0x00 with a 1-tick high glitch at tick M of bit 3 -> all 8 strobes carry 0; frame_done asserts.
- Framing error / break: send 0x55 with stop bit low, then hold rx_in low for 40 bit times -> 8 strobes, then exactly one framing_error; no further strobes until rx_in returns high and a new start bit arrives.
- Back-to-back frames: send 0x3C then 0xC3 with zero idle time between them -> 16 data strobes carrying the correct bits and 2 frame_done strobes.
- Reset mid-frame: assert rst_n=0 for 1 clk during bit 4 of 0xFF -> all outputs go to 0 at that edge; no frame_done; a following frame of 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver state encoding,
// default frame geometry and the 3-sample majority vote used at mid-bit.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int UART_OVERSAMPLE_DEFAULT = 16;
    localparam int UART_DATA_BITS_DEFAULT  = 8;

    // Two-out-of-three vote over the mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Multi-flop synchroniser for an asynchronous UART line input. Loads
// RESET_VALUE (idle-high by default) on reset so the receiver never sees a
// spurious start bit coming out of reset.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   d      : asynchronous line input
//   q      : synchronised line, STAGES clocks of latency
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: reset is sampled inside the clocked block, so it only takes
    // effect on a clock edge; rst_n must be held across at least one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RESET_VALUE}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// UART receive front-end. Synchronises rx_in, validates the start bit by a
// mid-bit majority vote, recovers each data bit by the same vote and presents
// it with a one-clock strobe in line order (first bit first). Stop-bit
// outcome is flagged as frame_done or framing_error.
// Ports:
//   clk            : system clock
//   rst_n          : synchronous active-low reset
//   rx_in          : asynchronous serial line, idle high
//   baud_tick      : one-clock pulse at OVERSAMPLE x baud rate
//   rcv_bit        : last recovered data bit, held between strobes
//   rcv_bit_valid  : one-clock strobe, rcv_bit carries a new data bit
//   frame_done     : one-clock strobe, stop bit sampled high
//   framing_error  : one-clock strobe, stop bit sampled low
//   rx_busy        : high whenever the receiver is not IDLE
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = UART_OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS   = UART_DATA_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    input  logic baud_tick,
    output logic rcv_bit,
    output logic rcv_bit_valid,
    output logic frame_done,
    output logic framing_error,
    output logic rx_busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int MID    = OVERSAMPLE / 2;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] SAMPLE_A  = TICK_W'(MID - 1);
    localparam logic [TICK_W-1:0] SAMPLE_B  = TICK_W'(MID);
    localparam logic [TICK_W-1:0] DECIDE    = TICK_W'(MID + 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [1:0]        samp_q, samp_d;
    logic              rcv_bit_d, valid_d, done_d, ferr_d;
    logic              vote, decide;

    uart_rx_sync #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx_s)
    );

    // The first two mid-bit samples are stored; the third is the live rx_s
    // on the decision tick, so the vote resolves on that tick.
    assign vote   = majority3(samp_q[0], samp_q[1], rx_s);
    assign decide = baud_tick && (tick_q == DECIDE);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        samp_d    = samp_q;
        rcv_bit_d = rcv_bit;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        if (baud_tick) begin
            if (tick_q == SAMPLE_A) samp_d[0] = rx_s;
            if (tick_q == SAMPLE_B) samp_d[1] = rx_s;

            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end

                START: begin
                    if (decide && vote) begin
                        // Line went back high by mid-bit: glitch, not a start.
                        state_d = IDLE;
                        tick_d  = '0;
                    end else if (tick_q == TICK_LAST) begin
                        state_d = DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                DATA: begin
                    if (decide) begin
                        rcv_bit_d = vote;
                        valid_d   = 1'b1;
                    end
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                STOP: begin
                    // Leaving at mid stop bit leaves half a bit of slack for
                    // a back-to-back start edge.
                    if (decide) begin
                        tick_d = '0;
                        if (vote) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                WAIT_IDLE: begin
                    // Park here during a break so it reports only once.
                    if (rx_s) state_d = IDLE;
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tick_q        <= '0;
            bit_q         <= '0;
            samp_q        <= '0;
            rcv_bit       <= 1'b0;
            rcv_bit_valid <= 1'b0;
            frame_done    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            samp_q        <= samp_d;
            rcv_bit       <= rcv_bit_d;
            rcv_bit_valid <= valid_d;
            frame_done    <= done_d;
            framing_error <= ferr_d;
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sampler
// Self-checking bench for uart_rx_sampler. The line is driven tick by tick
// from frame descriptions; the expected result is the data bits of each sent
// byte, LSB first, plus the stop-bit outcome.
// -----------------------------------------------------------------------------
module tb_uart_rx_sampler;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int M  = OS / 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_in = 1'b1;
    logic baud_tick = 1'b0;
    logic rcv_bit, rcv_bit_valid, frame_done, framing_error, rx_busy;

    int total = 0;
    int bad   = 0;
    int tick_div = 4;
    int div_cnt  = 0;

    bit got_q[$];
    int done_cnt = 0;
    int ferr_cnt = 0;

    uart_rx_sampler #(
        .OVERSAMPLE  (OS),
        .DATA_BITS   (DB),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_in         (rx_in),
        .baud_tick     (baud_tick),
        .rcv_bit       (rcv_bit),
        .rcv_bit_valid (rcv_bit_valid),
        .frame_done    (frame_done),
        .framing_error (framing_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one pulse every tick_div clocks (tick_div=1 is continuous).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (div_cnt >= tick_div - 1) begin
                div_cnt   = 0;
                baud_tick = 1'b1;
            end else begin
                div_cnt   = div_cnt + 1;
                baud_tick = 1'b0;
            end
        end
    end

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rcv_bit_valid) got_q.push_back(rcv_bit);
            if (frame_done) begin
                done_cnt++;
                check_int("busy_low_with_done", int'(rx_busy), 0);
            end
            if (framing_error) ferr_cnt++;
            if (rcv_bit_valid || frame_done || framing_error)
                check_int("strobe_onehot",
                          int'(rcv_bit_valid) + int'(frame_done) + int'(framing_error), 1);
        end
    end

    task automatic clear_obs();
        got_q.delete();
        done_cnt = 0;
        ferr_cnt = 0;
    endtask

    // Hold the line at level for n baud ticks; returns on the posedge of the
    // n-th tick. Bounded wait per tick.
    task automatic line(input bit level, input int n);
        #2 rx_in = level;
        for (int k = 0; k < n; k++) begin
            int guard;
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
                if (guard > 64) begin
                    $display("FAIL tick_timeout observed=no_tick expected=tick");
                    $fatal(1, "baud tick generator stalled");
                end
            end while (!baud_tick);
        end
    endtask

    // Start bit, DB data bits LSB first, stop bit. Optionally inverts the line
    // for one tick (gtick) inside data bit gbit.
    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input int gbit, input int gtick);
        line(1'b0, OS);
        for (int i = 0; i < DB; i++) begin
            if (i == gbit) begin
                for (int t = 0; t < OS; t++)
                    line((t == gtick) ? ~d[i] : d[i], 1);
            end else begin
                line(d[i], OS);
            end
        end
        line(stop, OS);
    endtask

    // Reference: the recovered stream is each byte's bits in line order.
    task automatic check_bytes(input string tag, input logic [7:0] bytes[$]);
        bit exp_q[$];
        foreach (bytes[b])
            for (int i = 0; i < DB; i++) exp_q.push_back(bytes[b][i]);
        check_int({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check_int($sformatf("%s_bit%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
        end
    endtask

    initial begin
        logic [7:0] sent[$];

        // Reset state
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_int("rst_rcv_bit", int'(rcv_bit), 0);
        check_int("rst_valid", int'(rcv_bit_valid), 0);
        check_int("rst_done", int'(frame_done), 0);
        check_int("rst_ferr", int'(framing_error), 0);
        check_int("rst_busy", int'(rx_busy), 0);
        rst_n = 1'b1;
        line(1'b1, 4);

        // Nominal 0xA5
        tick_div = 4;
        clear_obs();
        send_frame(8'hA5, 1'b1, -1, -1);
        line(1'b1, 4);
        sent = '{8'hA5};
        check_bytes("nominal", sent);
        check_int("nominal_done", done_cnt, 1);
        check_int("nominal_ferr", ferr_cnt, 0);
        check_int("nominal_busy_after", int'(rx_busy), 0);

        // False start: 3 ticks low
        clear_obs();
        line(1'b0, 3);
        #3 check_int("false_start_busy", int'(rx_busy), 1);
        line(1'b1, 10);
        #3 check_int("false_start_idle", int'(rx_busy), 0);
        line(1'b1, 4);
        check_int("false_start_strobes", got_q.size() + done_cnt + ferr_cnt, 0);

        // Noise rejection: one-tick glitch at tick M of bit 3
        clear_obs();
        send_frame(8'h00, 1'b1, 3, M);
        line(1'b1, 4);
        sent = '{8'h00};
        check_bytes("glitch", sent);
        check_int("glitch_done", done_cnt, 1);

        // Framing error then break of 40 bit times
        clear_obs();
        send_frame(8'h55, 1'b0, -1, -1);
        line(1'b0, 40 * OS);
        sent = '{8'h55};
        check_bytes("break", sent);
        check_int("break_ferr", ferr_cnt, 1);
        check_int("break_done", done_cnt, 0);
        check_int("break_busy", int'(rx_busy), 1);
        clear_obs();
        line(1'b1, 2 * OS);
        check_int("break_release_strobes", got_q.size() + done_cnt + ferr_cnt, 0);
        check_int("break_release_idle", int'(rx_busy), 0);
        send_frame(8'h96, 1'b1, -1, -1);
        line(1'b1, 4);
        sent = '{8'h96};
        check_bytes("after_break", sent);
        check_int("after_break_done", done_cnt, 1);

        // Back-to-back frames, continuous tick
        tick_div = 1;
        clear_obs();
        send_frame(8'h3C, 1'b1, -1, -1);
        send_frame(8'hC3, 1'b1, -1, -1);
        line(1'b1, 4);
        sent = '{8'h3C, 8'hC3};
        check_bytes("b2b", sent);
        check_int("b2b_done", done_cnt, 2);
        check_int("b2b_ferr", ferr_cnt, 0);

        // Reset during bit 4 of 0xFF
        tick_div = 4;
        clear_obs();
        line(1'b0, OS);
        line(1'b1, 4 * OS + 4);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_int("midrst_rcv_bit", int'(rcv_bit), 0);
        check_int("midrst_valid", int'(rcv_bit_valid), 0);
        check_int("midrst_done", int'(frame_done), 0);
        check_int("midrst_ferr", int'(framing_error), 0);
        check_int("midrst_busy", int'(rx_busy), 0);
        rst_n = 1'b1;
        line(1'b1, 5 * OS);
        check_int("midrst_bits_before", got_q.size(), 4);
        check_int("midrst_no_done", done_cnt, 0);
        clear_obs();
        send_frame(8'h81, 1'b1, -1, -1);
        line(1'b1, 4);
        sent = '{8'h81};
        check_bytes("after_rst", sent);
        check_int("after_rst_done", done_cnt, 1);

        // Randomised frames and tick cadences
        clear_obs();
        sent.delete();
        for (int f = 0; f < 12; f++) begin
            logic [7:0] d;
            d = 8'($urandom);
            tick_div = int'($urandom_range(1, 6));
            sent.push_back(d);
            send_frame(d, 1'b1, -1, -1);
            line(1'b1, int'($urandom_range(0, 3)));
        end
        line(1'b1, 4);
        check_bytes("random", sent);
        check_int("random_done", done_cnt, 12);
        check_int("random_ferr", ferr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
